// File: rtl/cv32e40p_pkg.sv
// Shared core constants used by the interrupt conditioning slice.
// IRQ_MASK marks the irq lines the core actually implements; all others are tied off.
package cv32e40p_pkg;

  localparam logic [31:0] IRQ_MASK = 32'hFFFF_0888;

  localparam int unsigned IRQ_SYNC_STAGES_DEFAULT = 2;

  function automatic logic [31:0] irq_id_onehot(input logic [4:0] id);
    return 32'h0000_0001 << id;
  endfunction

endpackage

// File: rtl/cv32e40p_irq_conditioner_if.sv
// Signal bundle between the interrupt sources / CSR side and the irq conditioner.
// master drives sources, ack and configuration; slave is the conditioner.
interface cv32e40p_irq_conditioner_if;
  logic [31:0] irq_src_i;
  logic [31:0] irq_o;
  logic        irq_ack_i;
  logic [4:0]  irq_id_i;
  logic        mode_we_i;
  logic [31:0] mode_wdata_i;
  logic [31:0] mode_o;
  logic [31:0] pend_clr_i;
  logic [31:0] pend_o;

  modport master (
    output irq_src_i, irq_ack_i, irq_id_i, mode_we_i, mode_wdata_i, pend_clr_i,
    input  irq_o, mode_o, pend_o
  );

  modport slave (
    input  irq_src_i, irq_ack_i, irq_id_i, mode_we_i, mode_wdata_i, pend_clr_i,
    output irq_o, mode_o, pend_o
  );
endinterface

// File: rtl/cv32e40p_irq_sync.sv
// Single-bit synchroniser, SYNC_STAGES flops, async reset to 0; latency SYNC_STAGES cycles.
// Kept standalone so it can be replaced by a technology synchroniser cell; no backpressure.
module cv32e40p_irq_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/cv32e40p_irq_conditioner.sv
// Synchronises the 32 external irq lines and applies per-line level/edge mode with sticky pending.
// Latency: level SYNC_STAGES cycles, edge SYNC_STAGES+1; no backpressure, ack/clear are pulses.
module cv32e40p_irq_conditioner
  import cv32e40p_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = IRQ_SYNC_STAGES_DEFAULT,
  parameter logic [31:0] EDGE_MODE_RST = 32'h0000_0000
) (
  input logic                         clk,
  input logic                         rst_n,
  cv32e40p_irq_conditioner_if.slave   bus
);

  logic [31:0] sync_raw;
  logic [31:0] sync_s;
  logic [31:0] prev_q;
  logic [31:0] pend_q;
  logic [31:0] pend_d;
  logic [31:0] mode_q;
  logic [31:0] mode_d;
  logic [31:0] rise;
  logic [31:0] ack_vec;
  logic [31:0] clr;

  for (genvar i = 0; i < 32; i++) begin : g_sync
    cv32e40p_irq_sync #(
      .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (bus.irq_src_i[i]),
      .q_o   (sync_raw[i])
    );
  end

  // Unimplemented lines are forced low right after the synchroniser.
  assign sync_s  = sync_raw & IRQ_MASK;
  assign rise    = sync_s & ~prev_q;
  assign ack_vec = bus.irq_ack_i ? irq_id_onehot(bus.irq_id_i) : 32'h0;
  assign clr     = ack_vec | bus.pend_clr_i;

  always_comb begin
    pend_d = mode_q & (rise | (pend_q & ~clr));
    mode_d = mode_q;
    if (bus.mode_we_i) begin
      mode_d = bus.mode_wdata_i & IRQ_MASK;
      // A line leaving edge mode loses its pending bit in the same update.
      pend_d = pend_d & bus.mode_wdata_i;
    end
    pend_d = pend_d & IRQ_MASK;
  end

  // prev tracks the synchronised line in both modes, so level->edge never sees a stale edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= '0;
      pend_q <= '0;
      mode_q <= EDGE_MODE_RST & IRQ_MASK;
    end else begin
      prev_q <= sync_s;
      pend_q <= pend_d;
      mode_q <= mode_d;
    end
  end

  assign bus.irq_o  = (~mode_q & sync_s) | (mode_q & pend_q);
  assign bus.mode_o = mode_q;
  assign bus.pend_o = pend_q;

endmodule

// File: doc/cv32e40p_irq_conditioner.md
Name: cv32e40p_irq_conditioner

Overview:
Conditioning stage placed directly upstream of the core interrupt controller, between the asynchronous external interrupt sources and the core irq_i[31:0] inputs. It synchronises each line and applies a per-line level or edge mode. Edge-mode lines get a sticky pending bit, which is cleared by the core interrupt acknowledge (irq_ack/irq_id) or by a software clear. All lines are presented to the controller as level-sensitive requests.

Parameters:
SYNC_STAGES, 2, number of synchroniser flops per line (legal range 2..4)
EDGE_MODE_RST, 32'h0000_0000, reset value of the edge-mode register (1 = edge, 0 = level)

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
irq_src_i  input  32  asynchronous interrupt source lines, active-high
irq_o  output  32  conditioned interrupt lines to the core irq_i
irq_ack_i  input  1  single-cycle pulse from the core when an interrupt is taken
irq_id_i  input  5  ID of the taken interrupt; valid when irq_ack_i=1
mode_we_i  input  1  write strobe for the edge-mode register
mode_wdata_i  input  32  edge-mode write data
mode_o  output  32  current edge-mode register value
pend_clr_i  input  32  software clear, one bit per edge-mode pending bit; single-cycle pulses
pend_o  output  32  pending register, for status readback

Behaviour:
- Reset (async, rst_n=0): all synchroniser flops = 0, prev register = 0, pend = 0, mode = EDGE_MODE_RST & IRQ_MASK. Therefore irq_o = 0, pend_o = 0.
- Masking: every line with IRQ_MASK[i]=0 is held at 0 throughout: sync output, pend, mode and irq_o.
- Synchroniser: SYNC_STAGES-flop chain per line; s[i] is the last stage. No combinational path from irq_src_i to any output.
- Level mode (mode[i]=0):
  - irq_o[i] = s[i], so the latency from irq_src_i to irq_o is SYNC_STAGES cycles.
  - pend[i] is held at 0.
  - irq_ack_i has no effect on the line.
- Edge mode (mode[i]=1):
  - prev[i] <= s[i] every cycle, in both modes.
  - rise[i] = s[i] & ~prev[i].
  - pend[i] sets on the clock after rise[i]; irq_o[i] = pend[i]. Latency is SYNC_STAGES+1 cycles.
  - Falling edges are ignored.
  - A line already high when reset is released produces one rising edge, because prev resets to 0.
- Clear terms: clr[i] = (irq_ack_i && irq_id_i==i) | pend_clr_i[i].
- Pending update: pend[i] <= mode[i] & (rise[i] | (pend[i] & ~clr[i])).
  - Simultaneous rise and clear: set wins; pend stays 1.
  - A repeated rise while already pending is coalesced into one pend bit (no counting).
  - An ack with irq_id_i pointing at a level line or a masked line has no effect.
- Mode write (mode_we_i=1): mode <= mode_wdata_i & IRQ_MASK, effective the next cycle.
  - Edge->level: the pending bit is cleared in the same update.
  - Level->edge: pend starts at 0. prev has been tracking continuously, so a line that is already high produces no edge.
  - A mode write in the same cycle as rise/clear uses the old mode for that cycle's pend computation, except that edge->level forces pend to 0.
- Reset asserted mid-operation drops all pending bits immediately (asynchronously). Lost edges are acceptable.
- mode_o and pend_o are registered values.

Decomposition:
- IRQ_MASK is reused from cv32e40p_pkg. Add IRQ_SYNC_STAGES_DEFAULT there.
- One sub-module, cv32e40p_irq_sync: a single-bit synchroniser with parameter SYNC_STAGES and async reset to 0, instantiated 32 times under a generate loop. It is kept separate so it can be swapped for a technology cell.

Test Plan:
- Reset release with irq_src_i=0 -> irq_o=0, pend_o=0, mode_o=EDGE_MODE_RST & IRQ_MASK.
- Level line 11 (MEI): drive irq_src_i[11]=1 at cycle 0 with SYNC_STAGES=2 -> irq_o[11]=1 at cycle 2. Deassert -> irq_o[11]=0 two cycles later. An ack with id 11 changes nothing.
- Edge line 16 (mode[16]=1): a 1-cycle pulse on irq_src_i[16] -> pend_o[16]=1 at cycle 3 and stays high after the source drops. irq_ack_i=1 with irq_id_i=16 -> pend_o[16]=0 the next cycle.
- Simultaneous set and clear on line 17: the rise on line 17 coincides with pend_clr_i[17]=1 while pend=1 -> pend_o[17] remains 1. A following clear with no rise -> 0.
- Mode switch on line 20: pend[20]=1; write mode[20]=0 -> pend_o[20]=0 and irq_o[20] follows s[20]. Write mode[20]=1 while the source is held high -> no new pending.
- Masked line 13 (IRQ_MASK[13]=0): toggle irq_src_i[13] and write mode bit 13 = 1 -> irq_o[13], pend_o[13] and mode_o[13] stay 0. Assert rst_n=0 while pend_o[16]=1 -> all outputs are 0 immediately.
